// File: rtl/sram_rr_arbiter.sv
// ============================================================================
// sram_rr_arbiter
// ----------------------------------------------------------------------------
// Two-port round-robin arbiter in front of the 32-bit SRAM controller.
// Requester 0 is the LSU data path. Requester 1 is a secondary master, such as
// the boot loader or the DMA. The arbiter captures one request at a time. It
// issues a single-cycle wren/rden strobe to the controller and waits for the
// controller ack. It then returns read data and a one-cycle done pulse to the
// owner. A watchdog aborts a transaction that sees no ack within
// TIMEOUT_CYCLES wait cycles; such a transaction ends with o_err=1 and
// o_rdata=0.
//
// Parameters
//   ADDR_W          SRAM byte-address width
//   DATA_W          data width; byte-mask width is DATA_W/8
//   TIMEOUT_CYCLES  wait cycles before abort (keep >= 8)
//
// Ports
//   i_clk, i_rst            clock (rising edge), async active-high reset
//   i_rN_req/we/addr/       requester N (N=0,1) level request and its fields,
//     wdata/bmask           held stable while req=1 until gnt
//   o_rN_gnt                1-cycle pulse: request captured (ISSUE cycle)
//   o_rN_done               1-cycle pulse: transaction finished
//   o_rdata                 read data, valid with done, held until next done
//   o_err                   high with done when the transaction timed out
//   o_busy                  FSM not idle
//   o_mem_addr/wdata/bmask  to controller i_ADDR/i_WDATA/i_BMASK
//   o_mem_wren/o_mem_rden   to controller i_WREN/i_RDEN, single-cycle strobes
//   i_mem_rdata/i_mem_ack   from controller o_RDATA/o_ACK
// ============================================================================
module sram_rr_arbiter #(
    parameter int ADDR_W         = 18,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,

    input  logic                i_r0_req,
    input  logic                i_r0_we,
    input  logic [ADDR_W-1:0]   i_r0_addr,
    input  logic [DATA_W-1:0]   i_r0_wdata,
    input  logic [DATA_W/8-1:0] i_r0_bmask,
    output logic                o_r0_gnt,
    output logic                o_r0_done,

    input  logic                i_r1_req,
    input  logic                i_r1_we,
    input  logic [ADDR_W-1:0]   i_r1_addr,
    input  logic [DATA_W-1:0]   i_r1_wdata,
    input  logic [DATA_W/8-1:0] i_r1_bmask,
    output logic                o_r1_gnt,
    output logic                o_r1_done,

    output logic [DATA_W-1:0]   o_rdata,
    output logic                o_err,
    output logic                o_busy,

    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_bmask,
    output logic                o_mem_wren,
    output logic                o_mem_rden,
    input  logic [DATA_W-1:0]   i_mem_rdata,
    input  logic                i_mem_ack
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state;
    logic             prio;       // requester favoured on a tie (0 after reset)
    logic             owner;      // requester that owns the current transaction
    logic             lat_we;     // captured direction of the current transaction
    logic [CNT_W-1:0] wd_cnt;     // WAIT cycles already elapsed
    logic             win;        // arbitration result: 1 = requester 1
    logic             win_we;

    // NOTE: every variable written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        win = 1'b0;
        if (i_r0_req && i_r1_req)
            win = prio;
        else if (i_r1_req)
            win = 1'b1;
        win_we = win ? i_r1_we : i_r0_we;
    end

    // NOTE: all state and registered outputs use non-blocking assignments, so
    // every right-hand side reads the pre-edge value regardless of statement
    // order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= S_IDLE;
            prio        <= 1'b0;
            owner       <= 1'b0;
            lat_we      <= 1'b0;
            wd_cnt      <= '0;
            o_r0_gnt    <= 1'b0;
            o_r1_gnt    <= 1'b0;
            o_r0_done   <= 1'b0;
            o_r1_done   <= 1'b0;
            o_rdata     <= '0;
            o_err       <= 1'b0;
            o_busy      <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_bmask <= '0;
            o_mem_wren  <= 1'b0;
            o_mem_rden  <= 1'b0;
        end else begin
            // Pulse outputs default low; each state raises only what it needs.
            o_r0_gnt   <= 1'b0;
            o_r1_gnt   <= 1'b0;
            o_r0_done  <= 1'b0;
            o_r1_done  <= 1'b0;
            o_err      <= 1'b0;
            o_mem_wren <= 1'b0;
            o_mem_rden <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (i_r0_req || i_r1_req) begin
                        owner       <= win;
                        prio        <= ~win;
                        lat_we      <= win_we;
                        o_mem_addr  <= win ? i_r1_addr  : i_r0_addr;
                        o_mem_wdata <= win ? i_r1_wdata : i_r0_wdata;
                        o_mem_bmask <= win ? i_r1_bmask : i_r0_bmask;
                        o_mem_wren  <= win_we;
                        o_mem_rden  <= ~win_we;
                        o_r0_gnt    <= ~win;
                        o_r1_gnt    <= win;
                        o_busy      <= 1'b1;
                        state       <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    wd_cnt <= '0;
                    state  <= S_WAIT;
                end

                S_WAIT: begin
                    // Ack wins over expiry in the same cycle.
                    if (i_mem_ack) begin
                        if (!lat_we)
                            o_rdata <= i_mem_rdata;
                        o_r0_done <= ~owner;
                        o_r1_done <= owner;
                        state     <= S_DONE;
                    end else if (wd_cnt == WD_LAST) begin
                        o_rdata   <= '0;
                        o_err     <= 1'b1;
                        o_r0_done <= ~owner;
                        o_r1_done <= owner;
                        state     <= S_DONE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end

                S_DONE: begin
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// ============================================================================
// tb_sram_rr_arbiter
// Directed bench for sram_rr_arbiter. A small controller model acks writes 2
// cycles and reads 4 cycles after the strobe. It keeps a 16-word memory
// indexed by addr[5:2]. A monitor logs grant and done events on the falling
// edge; the directed sequences compare those logs with hand-computed cycle
// numbers and data.
// ============================================================================
module tb_sram_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        r0_req = 1'b0, r0_we = 1'b0;
    logic [17:0] r0_addr = '0;
    logic [31:0] r0_wdata = '0;
    logic [3:0]  r0_bmask = '0;
    logic        r1_req = 1'b0, r1_we = 1'b0;
    logic [17:0] r1_addr = '0;
    logic [31:0] r1_wdata = '0;
    logic [3:0]  r1_bmask = '0;

    logic        r0_gnt, r0_done, r1_gnt, r1_done;
    logic [31:0] rdata;
    logic        err, busy;
    logic [17:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_bmask;
    logic        mem_wren, mem_rden;
    logic [31:0] mem_rdata = 32'h5A5A_5A5A;
    logic        mem_ack;

    sram_rr_arbiter #(.ADDR_W(18), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_r0_req(r0_req), .i_r0_we(r0_we), .i_r0_addr(r0_addr),
        .i_r0_wdata(r0_wdata), .i_r0_bmask(r0_bmask),
        .o_r0_gnt(r0_gnt), .o_r0_done(r0_done),
        .i_r1_req(r1_req), .i_r1_we(r1_we), .i_r1_addr(r1_addr),
        .i_r1_wdata(r1_wdata), .i_r1_bmask(r1_bmask),
        .o_r1_gnt(r1_gnt), .o_r1_done(r1_done),
        .o_rdata(rdata), .o_err(err), .o_busy(busy),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_bmask(mem_bmask),
        .o_mem_wren(mem_wren), .o_mem_rden(mem_rden),
        .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------------------------------------------------------- checks
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ------------------------------------------------------ controller model
    logic        ack_en = 1'b1;
    logic        stray_ack = 1'b0;
    logic        model_ack = 1'b0;
    int          cd = 0;
    logic        m_we = 1'b0;
    logic [3:0]  m_idx = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] mem [16];

    initial for (int i = 0; i < 16; i++) mem[i] = '0;

    assign mem_ack = model_ack | stray_ack;

    always @(negedge clk) begin
        model_ack = 1'b0;
        mem_rdata = 32'h5A5A_5A5A;
        if (rst) begin
            cd = 0;
        end else begin
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    model_ack = 1'b1;
                    if (m_we) mem[m_idx] = m_wdata;
                    else      mem_rdata  = mem[m_idx];
                end
            end
            if (ack_en && (mem_wren || mem_rden)) begin
                cd      = mem_wren ? 2 : 4;
                m_we    = mem_wren;
                m_idx   = mem_addr[5:2];
                m_wdata = mem_wdata;
            end
        end
    end

    // -------------------------------------------------------------- monitor
    int   n_gnt = 0, n_done = 0, n_wren = 0, n_rden = 0;
    bit   outstanding = 1'b0;
    int   gnt_cyc[$];
    bit   gnt_who[$];
    int   done_cyc = 0;
    bit   done_who = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_wren) n_wren++;
            if (mem_rden) n_rden++;
            if (r0_gnt || r1_gnt) begin
                check("gnt_one_hot", {r0_gnt, r1_gnt} == 2'b11, 1'b0);
                check("gnt_without_done", outstanding, 1'b0);
                check("strobe_one_hot", mem_wren ^ mem_rden, 1'b1);
                outstanding = 1'b1;
                gnt_cyc.push_back(cyc);
                gnt_who.push_back(r1_gnt);
                n_gnt++;
            end
            if (r0_done || r1_done) begin
                check("done_owner", r1_done, gnt_who[$]);
                outstanding = 1'b0;
                done_cyc = cyc;
                done_who = r1_done;
                n_done++;
            end
        end
    end

    // -------------------------------------------------------------- helpers
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_for(input string tag, input bit on_done, input int target, input int budget);
        int k = 0;
        while (((on_done ? n_done : n_gnt) < target) && (k < budget)) begin
            step(1);
            k++;
        end
        check(tag, ((on_done ? n_done : n_gnt) >= target), 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // ------------------------------------------------------------ sequences
    int t0, g, tr, base, dn, w0, rd0;

    initial begin
        // Reset state
        step(3);
        check("rst_busy", busy, 1'b0);
        check("rst_wren", mem_wren, 1'b0);
        check("rst_rden", mem_rden, 1'b0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_err", err, 1'b0);
        rst = 1'b0;
        step(1);

        // 1: r0 write
        t0 = cyc; w0 = n_wren;
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 18'h02004;
        r0_wdata = 32'hDEAD_BEEF; r0_bmask = 4'hF;
        wait_for("t1_gnt_seen", 1'b0, 1, 8);
        check("t1_gnt_cyc", gnt_cyc[$], t0 + 1);
        check("t1_gnt_who", gnt_who[$], 1'b0);
        check("t1_wren", mem_wren, 1'b1);
        check("t1_addr", mem_addr, 18'h02004);
        check("t1_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("t1_bmask", mem_bmask, 4'hF);
        check("t1_busy", busy, 1'b1);
        r0_req = 1'b0;
        wait_for("t1_done_seen", 1'b1, 1, 10);
        check("t1_done_cyc", done_cyc, t0 + 4);
        check("t1_err", err, 1'b0);
        check("t1_rdata_kept", rdata, 32'h0);
        check("t1_wren_cycles", n_wren - w0, 1);
        step(1);
        check("t1_idle_busy", busy, 1'b0);

        // 2: r1 read of the same address
        t0 = cyc; rd0 = n_rden;
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 18'h02004; r1_bmask = 4'hF;
        wait_for("t2_gnt_seen", 1'b0, 2, 8);
        check("t2_gnt_cyc", gnt_cyc[$], t0 + 1);
        check("t2_gnt_who", gnt_who[$], 1'b1);
        check("t2_rden", mem_rden, 1'b1);
        r1_req = 1'b0;
        wait_for("t2_done_seen", 1'b1, 2, 12);
        check("t2_done_cyc", done_cyc, t0 + 6);
        check("t2_done_who", done_who, 1'b1);
        check("t2_rdata", rdata, 32'hDEAD_BEEF);
        check("t2_err", err, 1'b0);
        check("t2_rden_cycles", n_rden - rd0, 1);
        step(3);
        check("t2_rdata_held", rdata, 32'hDEAD_BEEF);

        // 6: stray ack in IDLE, then r0 request held through the transaction
        stray_ack = 1'b1;
        step(1);
        stray_ack = 1'b0;
        step(3);
        check("t6_stray_no_done", n_done, 2);
        check("t6_stray_busy", busy, 1'b0);
        t0 = cyc;
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 18'h02008;
        r0_wdata = 32'h1234_5678; r0_bmask = 4'h0;
        wait_for("t6_gnt_seen", 1'b0, 3, 8);
        check("t6_gnt_cyc", gnt_cyc[$], t0 + 1);
        check("t6_bmask_zero", mem_bmask, 4'h0);
        wait_for("t6_done_seen", 1'b1, 3, 10);
        check("t6_done_cyc", done_cyc, t0 + 4);
        check("t6_no_reissue_in_wait", n_gnt, 3);
        wait_for("t6_regnt_seen", 1'b0, 4, 6);
        check("t6_regnt_cyc", gnt_cyc[$], t0 + 6);
        check("t6_regnt_who", gnt_who[$], 1'b0);
        r0_req = 1'b0;
        wait_for("t6_redone_seen", 1'b1, 4, 10);

        // 3: both requesting continuously after reset
        rst = 1'b1;
        outstanding = 1'b0;
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 18'h02004;
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 18'h02008;
        step(2);
        check("t3_rst_rdata", rdata, 32'h0);
        rst = 1'b0;
        tr = cyc; base = n_gnt;
        wait_for("t3_gnts_seen", 1'b0, base + 4, 60);
        r0_req = 1'b0; r1_req = 1'b0;
        check("t3_order0", gnt_who[base], 1'b0);
        check("t3_order1", gnt_who[base + 1], 1'b1);
        check("t3_order2", gnt_who[base + 2], 1'b0);
        check("t3_order3", gnt_who[base + 3], 1'b1);
        check("t3_first_cyc", gnt_cyc[base], tr + 1);
        check("t3_spacing", gnt_cyc[base + 1] - gnt_cyc[base], 7);
        wait_for("t3_done_seen", 1'b1, n_done + 1, 12);
        check("t3_last_rdata", rdata, 32'h1234_5678);

        // 4: controller never acks
        step(1);
        ack_en = 1'b0;
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 18'h02004;
        wait_for("t4_gnt_seen", 1'b0, n_gnt + 1, 6);
        r0_req = 1'b0;
        g = gnt_cyc[$];
        wait_for("t4_done_seen", 1'b1, n_done + 1, 30);
        check("t4_done_cyc", done_cyc, g + 17);
        check("t4_done_who", done_who, 1'b0);
        check("t4_err", err, 1'b1);
        check("t4_rdata_zero", rdata, 32'h0);
        step(1);
        check("t4_err_pulse", err, 1'b0);
        ack_en = 1'b1;
        r1_req = 1'b1; r1_we = 1'b1; r1_addr = 18'h0200C; r1_wdata = 32'hCAFE_F00D;
        wait_for("t4_next_gnt_seen", 1'b0, n_gnt + 1, 6);
        r1_req = 1'b0;
        g = gnt_cyc[$];
        wait_for("t4_next_done_seen", 1'b1, n_done + 1, 10);
        check("t4_next_done_cyc", done_cyc, g + 3);
        check("t4_next_err", err, 1'b0);

        // 5: reset during WAIT of a read
        step(1);
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 18'h02004;
        wait_for("t5_gnt_seen", 1'b0, n_gnt + 1, 6);
        r0_req = 1'b0;
        step(2);
        check("t5_busy_before", busy, 1'b1);
        dn = n_done;
        #2 rst = 1'b1;
        #1;
        check("t5_busy_async", busy, 1'b0);
        check("t5_addr_async", mem_addr, 18'h0);
        check("t5_rden_async", mem_rden, 1'b0);
        outstanding = 1'b0;
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 18'h02008;
        step(3);
        check("t5_no_done_in_rst", n_done, dn);
        rst = 1'b0;
        tr = cyc;
        wait_for("t5_r1_gnt_seen", 1'b0, n_gnt + 1, 6);
        r1_req = 1'b0;
        check("t5_r1_gnt_cyc", gnt_cyc[$], tr + 1);
        check("t5_r1_gnt_who", gnt_who[$], 1'b1);
        check("t5_no_stale_done", n_done, dn);
        wait_for("t5_r1_done_seen", 1'b1, dn + 1, 12);
        check("t5_r1_rdata", rdata, 32'h1234_5678);
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
